// File: rtl/multicycle_alu.sv
// rtl/multicycle_alu.sv - flag-setting ALU with a shift-add multi-cycle multiplier
//
// Ports:
//   clk, reset      rising-edge clock, synchronous active-high reset
//   start           operation request, only accepted while idle
//   Op[4:0]         operation select
//   A, B            operands, captured at the start edge
//   S               update the Z/N/C/V flags when the operation completes
//   out             registered result
//   zero, n, c, v   registered condition flags
//   busy            a multiply is in progress
//   done            one-cycle completion pulse
module multicycle_alu #(
    parameter int WIDTH  = 32,
    parameter int MUL_EN = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [4:0]       Op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             S,
    output logic [WIDTH-1:0] out,
    output logic             zero,
    output logic             n,
    output logic             c,
    output logic             v,
    output logic             busy,
    output logic             done
);

    localparam logic [4:0] OP_MUL = 5'b10100;
    localparam int         CW     = $clog2(WIDTH) + 1;

    typedef enum logic {IDLE, MUL} state_t;
    state_t state, state_next;

    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] acc, mcand, mplier, mul_sum;
    logic             s_q;

    logic is_mul, accept, mul_last;

    // ALU decode results
    logic [WIDTH-1:0] lres, x, y, val;
    logic [2:0]       k;
    logic             arith, v_from_add, v_zero, wr, def;
    logic [WIDTH+1:0] sum_u, sum_s;
    logic             add_c, add_v;

    assign is_mul   = (Op == OP_MUL) && (MUL_EN != 0);
    assign accept   = (state == IDLE) && start;
    assign mul_last = (state == MUL) && (cnt == CW'(WIDTH - 1));
    assign mul_sum  = acc + (mplier[0] ? mcand : '0);

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (start && is_mul) state_next = MUL;
            MUL:  if (mul_last)        state_next = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        busy = (state == MUL);
    end

    // Every add/subtract form is x + y + k; subtraction feeds ~operand with
    // k=1 (or k=c for the borrow forms), so C falls out as NOT borrow.
    always_comb begin
        lres       = '0;
        x          = '0;
        y          = '0;
        k          = 3'd0;
        arith      = 1'b0;
        v_from_add = 1'b0;
        v_zero     = 1'b0;
        wr         = 1'b1;
        def        = 1'b1;
        case (Op)
            5'b00000: begin lres = A & B;  v_zero = 1'b1; end
            5'b00001: begin lres = A ^ B;  v_zero = 1'b1; end
            5'b00010: begin x = A; y = ~B; k = 3'd1;         arith = 1'b1; v_from_add = 1'b1; end
            5'b00011: begin x = B; y = ~A; k = 3'd1;         arith = 1'b1; v_from_add = 1'b1; end
            5'b00100: begin x = A; y = B;  k = 3'd0;         arith = 1'b1; v_from_add = 1'b1; end
            5'b00101: begin x = A; y = B;  k = {2'b00, c};   arith = 1'b1; v_from_add = 1'b1; end
            5'b00110: begin x = A; y = ~B; k = {2'b00, c};   arith = 1'b1; v_from_add = 1'b1; end
            5'b00111: begin x = B; y = ~A; k = {2'b00, c};   arith = 1'b1; v_from_add = 1'b1; end
            5'b01000: begin lres = A & B;  v_zero = 1'b1; wr = 1'b0; end
            5'b01001: begin lres = A ^ B;  v_zero = 1'b1; wr = 1'b0; end
            5'b01010: begin x = A; y = ~B; k = 3'd1; arith = 1'b1; v_from_add = 1'b1; wr = 1'b0; end
            5'b01011: begin x = A; y = B;  k = 3'd0; arith = 1'b1; v_from_add = 1'b1; wr = 1'b0; end
            5'b01100: begin lres = A | B;  v_zero = 1'b1; end
            5'b01101: begin lres = B;      v_zero = 1'b1; end
            5'b01110: begin lres = A & ~B; v_zero = 1'b1; end
            5'b01111: begin lres = ~B;     v_zero = 1'b1; end
            5'b10000: begin lres = A; end
            5'b10001: begin x = A; y = '0;     k = 3'd4; arith = 1'b1; v_from_add = 1'b1; end
            5'b10010: begin x = A; y = B;      k = 3'd4; arith = 1'b1; v_from_add = 1'b1; end
            5'b10011: begin x = A; y = B << 2; k = 3'd0; arith = 1'b1; end
            default:  def = 1'b0;
        endcase
    end

    // Two guard bits hold the exact sum: unsigned overflow gives C, and a
    // signed result that does not survive truncation to WIDTH bits gives V.
    always_comb begin
        sum_u = {2'b00, x} + {2'b00, y} + {{(WIDTH-1){1'b0}}, k};
        sum_s = {{2{x[WIDTH-1]}}, x} + {{2{y[WIDTH-1]}}, y} + {{(WIDTH-1){1'b0}}, k};
        add_c = |sum_u[WIDTH+1:WIDTH];
        add_v = (sum_s != {{2{sum_s[WIDTH-1]}}, sum_s[WIDTH-1:0]});
        val   = arith ? sum_u[WIDTH-1:0] : lres;
    end

    // Datapath and flags
    always_ff @(posedge clk) begin
        if (reset) begin
            out    <= '0;
            zero   <= 1'b0;
            n      <= 1'b0;
            c      <= 1'b0;
            v      <= 1'b0;
            done   <= 1'b0;
            cnt    <= '0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            s_q    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                if (is_mul) begin
                    acc    <= '0;
                    mcand  <= A;
                    mplier <= B;
                    cnt    <= '0;
                    s_q    <= S;
                end else begin
                    done <= 1'b1;
                    if (def) begin
                        if (wr) out <= val;
                        if (S) begin
                            n    <= val[WIDTH-1];
                            zero <= (val == '0);
                            if (arith)           c <= add_c;
                            if (v_from_add)      v <= add_v;
                            else if (v_zero)     v <= 1'b0;
                        end
                    end
                end
            end else if (state == MUL) begin
                // One multiplier bit per cycle; the last step writes out directly.
                if (mul_last) begin
                    out  <= mul_sum;
                    done <= 1'b1;
                    if (s_q) begin
                        n    <= mul_sum[WIDTH-1];
                        zero <= (mul_sum == '0);
                    end
                end else begin
                    acc    <= mul_sum;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + CW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_multicycle_alu.sv
// tb/tb_multicycle_alu.sv - scoreboard bench for multicycle_alu
module tb_multicycle_alu;

    localparam longint TWO32 = 64'sh1_0000_0000;
    localparam longint SMAX  = 64'sh7fff_ffff;
    localparam longint SMIN  = -64'sh8000_0000;

    logic        clk = 1'b0;
    logic        reset, start, S;
    logic [4:0]  Op;
    logic [31:0] A, B;
    logic [31:0] out;
    logic        zero, n, c, v, busy, done;

    multicycle_alu #(.WIDTH(32), .MUL_EN(1)) dut (
        .clk(clk), .reset(reset), .start(start), .Op(Op), .A(A), .B(B), .S(S),
        .out(out), .zero(zero), .n(n), .c(c), .v(v), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] o;
        logic        z, nn, cc, vv;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        mon_e;
    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] m_out;
    logic        m_z, m_n, m_c, m_v;
    logic        prev_done = 1'b0;
    int          busy_cnt;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: exact 64-bit arithmetic, pushes the expected end state.
    task automatic model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b, input logic s);
        longint      ua, ub, sa, sb, us, ss, cin;
        logic [31:0] r, bs;
        logic        wr, def, arith, cn;
        int          kv;
        exp_t        e;
        ua = longint'({32'b0, a});
        ub = longint'({32'b0, b});
        sa = longint'(signed'(a));
        sb = longint'(signed'(b));
        cin = m_c ? 1 : 0;
        bs = b << 2;
        wr = 1'b1; def = 1'b1; arith = 1'b0; kv = 0; r = '0; us = 0; ss = 0; cn = 1'b0;
        case (op)
            5'd0:  begin r = a & b; kv = 2; end
            5'd1:  begin r = a ^ b; kv = 2; end
            5'd2:  begin us = ua - ub; ss = sa - sb; cn = (ua >= ub); arith = 1'b1; kv = 1; end
            5'd3:  begin us = ub - ua; ss = sb - sa; cn = (ub >= ua); arith = 1'b1; kv = 1; end
            5'd4:  begin us = ua + ub; ss = sa + sb; cn = (us >= TWO32); arith = 1'b1; kv = 1; end
            5'd5:  begin us = ua + ub + cin; ss = sa + sb + cin; cn = (us >= TWO32); arith = 1'b1; kv = 1; end
            5'd6:  begin us = ua - ub - (1 - cin); ss = sa - sb - (1 - cin); cn = (ua >= ub + 1 - cin); arith = 1'b1; kv = 1; end
            5'd7:  begin us = ub - ua - (1 - cin); ss = sb - sa - (1 - cin); cn = (ub >= ua + 1 - cin); arith = 1'b1; kv = 1; end
            5'd8:  begin r = a & b; kv = 2; wr = 1'b0; end
            5'd9:  begin r = a ^ b; kv = 2; wr = 1'b0; end
            5'd10: begin us = ua - ub; ss = sa - sb; cn = (ua >= ub); arith = 1'b1; kv = 1; wr = 1'b0; end
            5'd11: begin us = ua + ub; ss = sa + sb; cn = (us >= TWO32); arith = 1'b1; kv = 1; wr = 1'b0; end
            5'd12: begin r = a | b; kv = 2; end
            5'd13: begin r = b; kv = 2; end
            5'd14: begin r = a & ~b; kv = 2; end
            5'd15: begin r = ~b; kv = 2; end
            5'd16: begin r = a; end
            5'd17: begin us = ua + 4; ss = sa + 4; cn = (us >= TWO32); arith = 1'b1; kv = 1; end
            5'd18: begin us = ua + ub + 4; ss = sa + sb + 4; cn = (us >= TWO32); arith = 1'b1; kv = 1; end
            5'd19: begin us = ua + longint'({32'b0, bs}); cn = (us >= TWO32); arith = 1'b1; end
            5'd20: begin r = a * b; end
            default: def = 1'b0;
        endcase
        if (arith) r = us[31:0];
        if (def) begin
            if (wr) m_out = r;
            if (s) begin
                m_n = r[31];
                m_z = (r == 32'd0);
                if (arith) m_c = cn;
                if (kv == 1) m_v = (ss > SMAX) || (ss < SMIN);
                if (kv == 2) m_v = 1'b0;
            end
        end
        e.o = m_out; e.z = m_z; e.nn = m_n; e.cc = m_c; e.vv = m_v;
        sb_q.push_back(e);
    endtask

    task automatic wait_done();
        for (int i = 0; i < 40 && !done; i++) @(negedge clk);
        check("done_seen", {63'b0, done}, 64'd1);
    endtask

    task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b, input logic s);
        @(negedge clk);
        Op = op; A = a; B = b; S = s; start = 1'b1;
        model(op, a, b, s);
        @(negedge clk);
        start = 1'b0; A = $urandom; B = $urandom; Op = 5'($urandom_range(0, 31));
        wait_done();
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 6))
            0: pick = 32'h0000_0000;
            1: pick = 32'h0000_0001;
            2: pick = 32'h7fff_ffff;
            3: pick = 32'h8000_0000;
            4: pick = 32'hffff_ffff;
            default: pick = $urandom;
        endcase
    endfunction

    // Scoreboard side: every done pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (done) begin
            check("done_single", {63'b0, prev_done}, 64'd0);
            check("done_expected", {63'b0, (sb_q.size() != 0)}, 64'd1);
            if (sb_q.size() != 0) begin
                mon_e = sb_q.pop_front();
                check("sb_out", {32'b0, out}, {32'b0, mon_e.o});
                check("sb_flags", {60'b0, zero, n, c, v}, {60'b0, mon_e.z, mon_e.nn, mon_e.cc, mon_e.vv});
            end
        end
        prev_done = done;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; start = 1'b0; S = 1'b0; Op = '0; A = '0; B = '0;
        m_out = '0; m_z = 1'b0; m_n = 1'b0; m_c = 1'b0; m_v = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("rst_out", {32'b0, out}, 64'd0);
        check("rst_flags", {60'b0, zero, n, c, v}, 64'd0);
        check("rst_busy_done", {62'b0, busy, done}, 64'd0);

        // Signed overflow on ADD
        issue(5'd4, 32'h7fff_ffff, 32'h0000_0001, 1'b1);
        check("add_ovf_out", {32'b0, out}, 64'h8000_0000);
        check("add_ovf_flags", {60'b0, zero, n, c, v}, 64'b0101);
        @(negedge clk);
        check("done_drop", {63'b0, done}, 64'd0);

        // SUB to zero, then flags held with S=0
        issue(5'd2, 32'd1, 32'd1, 1'b1);
        check("sub_zero_flags", {60'b0, zero, n, c, v}, 64'b1010);
        issue(5'd4, 32'd0, 32'd1, 1'b1);
        issue(5'd2, 32'd1, 32'd1, 1'b0);
        check("sub_s0_out", {32'b0, out}, 64'd0);
        check("sub_s0_flags", {60'b0, zero, n, c, v}, 64'b0000);

        // MOV, CMP keeps out, carry chain into ADC
        issue(5'd13, 32'd0, 32'h1234, 1'b1);
        issue(5'd10, 32'd5, 32'd7, 1'b1);
        check("cmp_out", {32'b0, out}, 64'h1234);
        check("cmp_flags", {60'b0, zero, n, c, v}, 64'b0100);
        issue(5'd4, 32'hffff_ffff, 32'd1, 1'b1);
        check("add_carry", {63'b0, c}, 64'd1);
        issue(5'd5, 32'd2, 32'd3, 1'b1);
        check("adc_out", {32'b0, out}, 64'd6);

        // Undefined opcode leaves state, still completes
        issue(5'd21, 32'h55, 32'haa, 1'b1);
        check("undef_out", {32'b0, out}, 64'd6);

        // Multiply timing with an ignored mid-operation start
        @(negedge clk);
        Op = 5'd20; A = 32'h0001_0000; B = 32'h0001_0001; S = 1'b1; start = 1'b1;
        model(5'd20, 32'h0001_0000, 32'h0001_0001, 1'b1);
        @(negedge clk);
        start = 1'b0; A = $urandom; B = $urandom;
        busy_cnt = 0;
        for (int i = 0; i < 40 && busy; i++) begin
            busy_cnt++;
            if (i == 5) begin start = 1'b1; Op = 5'd4; end
            else start = 1'b0;
            @(negedge clk);
        end
        start = 1'b0;
        check("mul_busy_cycles", 64'(busy_cnt), 64'd32);
        check("mul_done", {63'b0, done}, 64'd1);
        check("mul_out", {32'b0, out}, 64'h0001_0000);

        // Random mix, including multiplies and undefined opcodes
        for (int i = 0; i < 60; i++)
            issue(5'($urandom_range(0, 23)), pick(), pick(), 1'($urandom_range(0, 1)));

        // Reset in the middle of a multiply
        @(negedge clk);
        Op = 5'd20; A = 32'd3; B = 32'd5; S = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_busy", {63'b0, busy}, 64'd0);
        check("abort_out", {32'b0, out}, 64'd0);
        check("abort_flags", {60'b0, zero, n, c, v}, 64'd0);
        check("abort_done", {63'b0, done}, 64'd0);
        m_out = '0; m_z = 1'b0; m_n = 1'b0; m_c = 1'b0; m_v = 1'b0;
        sb_q.delete();
        repeat (40) @(negedge clk);
        issue(5'd4, 32'd2, 32'd2, 1'b1);
        check("post_abort_add", {32'b0, out}, 64'd4);

        // Reset wins over a simultaneous start
        @(negedge clk);
        Op = 5'd4; A = 32'd9; B = 32'd9; S = 1'b1; start = 1'b1; reset = 1'b1;
        @(negedge clk);
        start = 1'b0; reset = 1'b0;
        m_out = '0; m_z = 1'b0; m_n = 1'b0; m_c = 1'b0; m_v = 1'b0;
        check("rst_prio_out", {32'b0, out}, 64'd0);
        check("rst_prio_done_busy", {62'b0, busy, done}, 64'd0);
        repeat (3) @(negedge clk);

        check("sb_empty", 64'(sb_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/multicycle_alu.md
MULTICYCLE_ALU -- requirements
Module: multicycle_alu

Interface
REQ-001 Parameter WIDTH, default 32, datapath and operand width in bits (legal 8..64).
REQ-002 Parameter MUL_EN, default 1; when 0, the MUL opcode is treated as undefined.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  request; sampled only while busy=0.
REQ-006 Op  input  5  operation select, encoding per REQ-014.
REQ-007 A  input  WIDTH  first operand.
REQ-008 B  input  WIDTH  second operand.
REQ-009 S  input  1  flag-update enable for the issued operation.
REQ-010 out  output  WIDTH  registered result.
REQ-011 zero, n, c, v  output  1 each  registered condition flags Z, N, C, V.
REQ-012 busy  output  1  high while a multi-cycle operation is in progress.
REQ-013 done  output  1  one-cycle pulse when an operation completes.

Function
REQ-014 Op encoding:
- 00000 AND; 00001 XOR; 00010 A-B; 00011 B-A; 00100 A+B.
- 00101 A+B+c; 00110 A-B-!c; 00111 B-A-!c.
- 01000 TST (A&B); 01001 TEQ (A^B); 01010 CMP (A-B); 01011 CMN (A+B).
- 01100 OR; 01101 B; 01110 A&~B; 01111 ~B.
- 10000 A; 10001 A+4; 10010 A+B+4; 10011 A+(signed B<<2).
- 10100 MUL, low WIDTH bits of A*B, unsigned.
- 10101-11111 undefined.
REQ-015 The carry-in for 00101-00111 SHALL be the internal registered c flag, not an external port.
REQ-016 The block SHALL implement FSM states IDLE and MUL.
REQ-017 IDLE with start=1 and a non-MUL Op: register the result at that edge, stay in IDLE, assert done in the following cycle.
REQ-018 IDLE with start=1 and Op=MUL: enter MUL and run a shift-add over WIDTH cycles, busy=1 from the cycle after the start edge.
REQ-019 MUL completion: the result registers at the WIDTH-th edge after the start edge; the FSM returns to IDLE with busy=0 and done=1 in the following cycle.
REQ-020 start SHALL be ignored while busy=1; operands SHALL be captured at the start edge, so later changes to A or B have no effect.
REQ-021 TST, TEQ, CMP and CMN SHALL leave out unchanged.
REQ-022 Undefined opcodes SHALL leave out and flags unchanged and still pulse done.
REQ-023 Flags SHALL update only at the completing edge and only when S=1; with S=0 all flags hold.
REQ-024 N SHALL be the MSB of the computed value, using the discarded value for TST/TEQ/CMP/CMN.
REQ-025 Z SHALL be 1 exactly when every bit of the computed value is 0.
REQ-026 C for additions SHALL be the carry-out of bit WIDTH-1.
REQ-027 C for subtractions SHALL be NOT borrow: A>=B unsigned gives C=1 for A-B.
REQ-028 C for logical ops, moves, 10000 and MUL SHALL be unchanged.
REQ-029 V for add and subtract forms SHALL be signed two's-complement overflow of the actual operands, including 4 for 10001/10010.
REQ-030 V for logical ops and moves SHALL be 0; V SHALL be unchanged for 10000, 10011 and MUL.
REQ-031 All arithmetic SHALL wrap modulo 2^WIDTH.
REQ-032 done SHALL never be high for more than one consecutive cycle per operation.

Reset
REQ-033 On reset=1 at a rising edge: out=0, zero=n=c=v=0, busy=0, done=0, FSM to IDLE.
REQ-034 Reset during MUL SHALL abort the operation: no done pulse and no partial result on out.
REQ-035 Reset SHALL take priority over a start asserted in the same cycle.

Verification (WIDTH=32)
REQ-036 ADD 0x7FFFFFFF+0x00000001, S=1 -> next cycle out=0x80000000, n=1 z=0 c=0 v=1, done=1 for one cycle.
REQ-037 SUB 1-1, S=1 -> out=0, z=1 c=1 n=0 v=0; repeat with S=0 after ADD 0+1 (S=1) -> flags stay n=0 z=0 c=0 v=0.
REQ-038 Sequence:
- out=0x1234 held from a prior MOV.
- CMP A=5 B=7, S=1 -> out=0x1234, n=1 z=0 c=0 v=0.
- ADD 0xFFFFFFFF+1, S=1 -> c=1.
- Then ADC 2+3 -> out=6.
REQ-039 MUL A=0x00010000 B=0x00010001 -> busy high 32 cycles, done in the 33rd cycle after start, out=0x00010000.
- A start pulsed mid-MUL is ignored.
REQ-040 Reset asserted 10 cycles into a MUL -> next cycle busy=0, out=0, flags 0, no done pulse; a following ADD 2+2 -> out=4.
